// File: rtl/dv_mem_pkg.sv
// ---------------------------------------------------------------------------
// dv_mem_pkg
//   Shared constants and helpers for the latency-accurate DV memory model
//   (dv_mem_model_rl) and its read-response pipeline (dv_mem_rd_pipe).
//   RL_MAX    : deepest read latency the response pipeline supports
//   LFSR_TAPS : Galois feedback mask of the 16-bit stall LFSR
//   lfsr_next : one Galois LFSR step (shift right, fold taps in on carry-out)
// ---------------------------------------------------------------------------
package dv_mem_pkg;

    localparam int          RL_MAX    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/dv_mem_rd_pipe.sv
// ---------------------------------------------------------------------------
// dv_mem_rd_pipe
//   RL-deep read-response shift register. A slot {vld, err, data} enters at
//   the accept edge and leaves RL-1 edges later on out_*. The response side
//   has no back-pressure, so there is no ready/stall logic here.
//   Ports:
//     clk, rst          clock, synchronous active-high clear of all slots
//     in_vld            read accepted this edge
//     in_err, in_data   error flag / data sampled at the accept edge
//     out_vld           single-cycle response pulse
//     out_err, out_data response payload; holds its last value when !out_vld
// ---------------------------------------------------------------------------
module dv_mem_rd_pipe
    import dv_mem_pkg::*;
#(
    parameter int DW = 16,
    parameter int RL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic          out_err,
    output logic [DW-1:0] out_data
);

    if (RL < 1 || RL > RL_MAX) begin : g_rl_chk
        $error("dv_mem_rd_pipe: RL=%0d outside 1..%0d", RL, RL_MAX);
    end

    typedef struct packed {
        logic          vld;
        logic          err;
        logic [DW-1:0] data;
    } rd_slot_t;

    rd_slot_t slot_q [RL];
    rd_slot_t slot_d [RL];

    // Valid bits always shift; payload only moves with a valid slot, so the
    // last stage keeps the previous response across bubbles.
    always_comb begin
        slot_d        = slot_q;
        slot_d[0].vld = in_vld;
        if (in_vld) begin
            slot_d[0].err  = in_err;
            slot_d[0].data = in_data;
        end
        for (int i = 1; i < RL; i++) begin
            slot_d[i].vld = slot_q[i-1].vld;
            if (slot_q[i-1].vld) begin
                slot_d[i].err  = slot_q[i-1].err;
                slot_d[i].data = slot_q[i-1].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RL; i++) slot_q[i] <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign out_vld  = slot_q[RL-1].vld;
    assign out_err  = slot_q[RL-1].err;
    assign out_data = slot_q[RL-1].data;

endmodule

// File: rtl/dv_mem_model_rl.sv
// ---------------------------------------------------------------------------
// dv_mem_model_rl
//   Behavioural DV memory with one valid/ready request port, byte-enable
//   writes and a fixed read latency of RL cycles from the accept edge.
//   Out-of-range reads return all-ones with rsp_err=1; out-of-range writes
//   are dropped. Memory contents survive reset; in-flight reads do not.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     req_valid/req_ready    request handshake (transfer on valid && ready)
//     req_we                 1 = write, 0 = read
//     req_addr, req_wdata    word address, write data
//     req_be                 per-byte write enables (ignored on reads)
//     rsp_valid              one-cycle pulse per accepted read
//     rsp_rdata, rsp_err     read data / out-of-range flag
//   Build option: define DV_MEM_STALL_EN to drive req_ready from a 16-bit
//   Galois LFSR (seeded with SEED) for ~25% reproducible stall cycles.
// ---------------------------------------------------------------------------
module dv_mem_model_rl
    import dv_mem_pkg::*;
#(
    parameter int          DW    = 16,
    parameter int          AW    = 20,
    parameter int          DEPTH = 2**AW,
    parameter int          RL    = 2,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
);

    localparam int          NB      = DW / 8;
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    if (DW % 8 != 0) begin : g_dw_chk
        $error("dv_mem_model_rl: DW=%0d is not a multiple of 8", DW);
    end
    // An all-zero seed would lock the stall LFSR at zero (permanent stall).
    if (SEED == 16'h0000) begin : g_seed_chk
        $error("dv_mem_model_rl: SEED must be non-zero");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic          ready_q, ready_d;
    logic          in_range;
    logic          accept;
    logic [IW-1:0] idx;
    logic [DW-1:0] rd_data;

    always_comb begin
        in_range = ({1'b0, req_addr} < DEPTH_W);
        idx      = req_addr[IW-1:0];
        // Reset wins over a handshake that happens to coincide with it.
        accept   = req_valid & ready_q & ~rst;
        rd_data  = in_range ? mem_q[idx] : {DW{1'b1}};
    end

`ifdef DV_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d  = lfsr_next(lfsr_q);
        ready_d = (lfsr_q[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end
`else
    always_comb ready_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= ready_d;
    end

    assign req_ready = ready_q;

    // Storage is deliberately not reset: contents must survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    dv_mem_rd_pipe #(.DW(DW), .RL(RL)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (accept & ~req_we),
        .in_err   (~in_range),
        .in_data  (rd_data),
        .out_vld  (rsp_valid),
        .out_err  (rsp_err),
        .out_data (rsp_rdata)
    );

`ifndef SYNTHESIS
    a_req_valid_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(req_valid))
        else $error("dv_mem_model_rl: req_valid is X/Z");
`endif

endmodule

// File: tb/tb_dv_mem_model_rl.sv
module tb_dv_mem_model_rl;

    localparam int DW    = 16;
    localparam int AW    = 20;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    be;
        logic [15:0]   exp_data;
        logic          exp_err;
    } vec_t;

    vec_t          vecs [$];
    logic [AW-1:0] s_addr [$];
    logic [16:0]   s_exp [$];
    logic [16:0]   exp_q [$];

    dv_mem_model_rl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RL(RL), .SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [AW-1:0] a,
                                input logic [15:0] d, input logic [1:0] be,
                                input logic [15:0] ed, input logic ee);
        vec_t v;
        v.name = nm; v.we = we; v.addr = a; v.wdata = d; v.be = be;
        v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Drive a request from a negedge, hold it until ready, return after the accept edge.
    task automatic accept(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic [1:0] be, output int stalls);
        stalls = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        while (!req_ready && stalls < 500) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 500) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Single transaction with exact-latency response check for reads.
    task automatic do_op(input vec_t v);
        int g;
        accept(v.we, v.addr, v.wdata, v.be, g);
        #1 req_valid = 1'b0;
        if (v.we) begin
            repeat (RL) @(negedge clk);
            chk({v.name, "_no_rsp"}, rsp_valid, 1'b0);
        end else begin
            for (int k = 1; k < RL; k++) begin
                @(negedge clk);
                chk({v.name, "_early"}, rsp_valid, 1'b0);
                @(posedge clk);
            end
            @(negedge clk);
            chk({v.name, "_vld"}, rsp_valid, 1'b1);
            chk({v.name, "_data"}, rsp_rdata, v.exp_data);
            chk({v.name, "_err"}, rsp_err, v.exp_err);
            @(negedge clk);
            chk({v.name, "_pulse"}, rsp_valid, 1'b0);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
        do_op(mk("wr", 1'b1, a, d, 2'b11, 16'h0, 1'b0));
    endtask

    // Streams reads from s_addr back-to-back; monitor checks order against s_exp.
    task automatic run_stream(input int n, output int stalls, output int span);
        int got, cyc, first_c, last_c;
        stalls = 0; got = 0; cyc = 0; first_c = 0; last_c = 0;
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int g;
                    accept(1'b0, s_addr[i], 16'h0, 2'b00, g);
                    stalls += g;
                    exp_q.push_back(s_exp[i]);
                end
                #1 req_valid = 1'b0;
            end
            begin
                while (got < n && cyc < 4*n + 100) begin
                    @(negedge clk);
                    cyc++;
                    if (rsp_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("stream_extra", 32'd1, 32'd0);
                        end else begin
                            logic [16:0] e;
                            e = exp_q.pop_front();
                            chk("stream_data", rsp_rdata, e[15:0]);
                            chk("stream_err", rsp_err, e[16]);
                        end
                        if (got == 0) first_c = cyc;
                        last_c = cyc;
                        got++;
                    end
                end
                chk("stream_count", got, n);
            end
        join
        span = last_c - first_c;
    endtask

    initial begin
        int stalls, span, nvld, n;

        vecs.push_back(mk("wr_beef",     1'b1, 20'h00010, 16'hBEEF, 2'b11, 16'h0000, 1'b0));
        vecs.push_back(mk("wr_hi_byte",  1'b1, 20'h00010, 16'h1200, 2'b10, 16'h0000, 1'b0));
        vecs.push_back(mk("be_merge",    1'b0, 20'h00010, 16'h0000, 2'b00, 16'h12EF, 1'b0));
        vecs.push_back(mk("wr_3344",     1'b1, 20'h00020, 16'h3344, 2'b11, 16'h0000, 1'b0));
        vecs.push_back(mk("wr_be0",      1'b1, 20'h00020, 16'hAAAA, 2'b00, 16'h0000, 1'b0));
        vecs.push_back(mk("wr_lo_byte",  1'b1, 20'h00020, 16'h0055, 2'b01, 16'h0000, 1'b0));
        vecs.push_back(mk("be_lo_noop",  1'b0, 20'h00020, 16'h0000, 2'b00, 16'h3355, 1'b0));
        vecs.push_back(mk("wr_a0",       1'b1, 20'h00000, 16'h1111, 2'b11, 16'h0000, 1'b0));
        vecs.push_back(mk("oor_read",    1'b0, 20'h00400, 16'h0000, 2'b00, 16'hFFFF, 1'b1));
        vecs.push_back(mk("oor_wr",      1'b1, 20'h00400, 16'hDEAD, 2'b11, 16'h0000, 1'b0));
        vecs.push_back(mk("a0_intact",   1'b0, 20'h00000, 16'h0000, 2'b00, 16'h1111, 1'b0));
        vecs.push_back(mk("wr_last",     1'b1, 20'h003FF, 16'h7777, 2'b11, 16'h0000, 1'b0));
        vecs.push_back(mk("last_word",   1'b0, 20'h003FF, 16'h0000, 2'b00, 16'h7777, 1'b0));
        vecs.push_back(mk("top_addr",    1'b0, 20'hFFFFF, 16'h0000, 2'b00, 16'hFFFF, 1'b1));
        vecs.push_back(mk("wr_lo_clr",   1'b1, 20'h00010, 16'h0000, 2'b01, 16'h0000, 1'b0));
        vecs.push_back(mk("be_lo_clear", 1'b0, 20'h00010, 16'h0000, 2'b00, 16'h1200, 1'b0));

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;

        // Reset: three cycles held, outputs at reset values, ready rises one edge after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
        end
        chk("rst_rdata", rsp_rdata, 16'h0000);
        chk("rst_err", rsp_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);
        chk("rsp_valid_after_rst", rsp_valid, 1'b0);

        foreach (vecs[i]) do_op(vecs[i]);

        // Four back-to-back reads return four consecutive in-order pulses.
        for (int i = 0; i < 4; i++) wr(AW'(i), 16'h00A0 + 16'(i));
        s_addr.delete(); s_exp.delete();
        for (int i = 0; i < 4; i++) begin
            s_addr.push_back(AW'(i));
            s_exp.push_back({1'b0, 16'h00A0 + 16'(i)});
        end
        run_stream(4, stalls, span);
`ifndef DV_MEM_STALL_EN
        chk("b2b_span", span, 3);
`endif

        // Reset with reads in flight: nothing emerges afterwards, memory survives.
        wr(20'h00030, 16'hCAFE);
        accept(1'b0, 20'h00030, 16'h0, 2'b00, stalls);
        accept(1'b0, 20'h00031, 16'h0, 2'b00, stalls);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", rsp_valid, 1'b0);
        rst = 1'b0;
        nvld = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) nvld++;
        end
        chk("midrst_no_rsp", nvld, 0);
        do_op(mk("mem_kept", 1'b0, 20'h00030, 16'h0, 2'b00, 16'hCAFE, 1'b0));

        // Long stream over a preloaded window, with occasional out-of-range reads.
        for (int j = 0; j < 64; j++) wr(AW'(12'h100 + j), 16'(j * 40503) ^ 16'h5A5A);
`ifdef DV_MEM_STALL_EN
        n = 1000;
`else
        n = 200;
`endif
        s_addr.delete(); s_exp.delete();
        for (int i = 0; i < n; i++) begin
            if (i % 37 == 36) begin
                s_addr.push_back(20'h80000 + AW'(i));
                s_exp.push_back({1'b1, 16'hFFFF});
            end else begin
                s_addr.push_back(AW'(12'h100 + (i % 64)));
                s_exp.push_back({1'b0, 16'((i % 64) * 40503) ^ 16'h5A5A});
            end
        end
        run_stream(n, stalls, span);
`ifdef DV_MEM_STALL_EN
        chk("stall_pct_in_20_30",
            32'(((stalls * 100) / (stalls + n) >= 20) && ((stalls * 100) / (stalls + n) <= 30)), 32'd1);
`else
        chk("no_stall", stalls, 0);
        chk("stream_span", span, n - 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
